// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : scancodes, direction encodings and receiver states.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  typedef logic [3:0] dir_t;   // {right, down, left, up}

  localparam logic [7:0] SC_W         = 8'h1D;
  localparam logic [7:0] SC_A         = 8'h1C;
  localparam logic [7:0] SC_S         = 8'h1B;
  localparam logic [7:0] SC_D         = 8'h23;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_UP_EXT    = 8'h75;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;

  localparam dir_t DIR_UP    = 4'b0001;
  localparam dir_t DIR_LEFT  = 4'b0010;
  localparam dir_t DIR_DOWN  = 4'b0100;
  localparam dir_t DIR_RIGHT = 4'b1000;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  // Swapping the two halves maps up<->down and left<->right.
  function automatic dir_t opposite_dir(input dir_t d);
    return {d[1:0], d[3:2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx : PS/2 frame receiver with synchronisers, parity and timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          bit_in;
  logic          timeout;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [CW-1:0] tmo_cnt;

  // Synchronisers reset high so an idle bus produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], kb_clk};
      dat_sync <= {dat_sync[0], kb_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = dat_sync[1];
  assign timeout = (state != RX_IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      // Timeout takes priority over a coincident clock edge.
      if (timeout) begin
        state   <= RX_IDLE;
        tmo_cnt <= '0;
        rx_err  <= 1'b1;
      end else if (fall) begin
        tmo_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!bit_in) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end else begin
              rx_err  <= 1'b1;
            end
          end
          RX_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_bit <= bit_in;
            state      <= RX_STOP;
          end
          RX_STOP: begin
            if (bit_in && (^{shift, parity_bit})) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err   <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_direction_decoder.sv
// ---------------------------------------------------------------------------
// ps2_direction_decoder : PS/2 keys to held Snake direction and start. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 100000,
  parameter dir_t INIT_DIR       = 4'b1000,
  parameter bit   BLOCK_REVERSE  = 1'b1
) (
  input  logic       master_clk,
  input  logic       reset_n,
  input  logic       KB_clk,
  input  logic       data,
  output logic       up,
  output logic       left,
  output logic       down,
  output logic       right,
  output logic       start,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  dir_t       dir;
  logic       start_q;
  logic       brk;
  logic       ext;
  dir_t       req_dir;
  logic       enter_hit;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (master_clk),
    .rst_n    (reset_n),
    .kb_clk   (KB_clk),
    .kb_data  (data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always_comb begin
    req_dir   = '0;
    enter_hit = 1'b0;
    if (!ext) begin
      case (rx_byte)
        SC_W:     req_dir   = DIR_UP;
        SC_A:     req_dir   = DIR_LEFT;
        SC_S:     req_dir   = DIR_DOWN;
        SC_D:     req_dir   = DIR_RIGHT;
        SC_ENTER: enter_hit = 1'b1;
        default:  ;
      endcase
    end else begin
      case (rx_byte)
        SC_UP_EXT:    req_dir = DIR_UP;
        SC_LEFT_EXT:  req_dir = DIR_LEFT;
        SC_DOWN_EXT:  req_dir = DIR_DOWN;
        SC_RIGHT_EXT: req_dir = DIR_RIGHT;
        default:      ;
      endcase
    end
  end

  // Prefix bytes only arm flags; the next ordinary byte consumes and clears them.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir     <= INIT_DIR;
      start_q <= 1'b0;
      brk     <= 1'b0;
      ext     <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk <= 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
        if (!brk) begin
          if ((req_dir != '0) &&
              !(BLOCK_REVERSE && (req_dir == opposite_dir(dir))))
            dir <= req_dir;
          if (enter_hit) start_q <= ~start_q;
        end
      end
    end
  end

  assign {right, down, left, up} = dir;
  assign start      = start_q;
  assign code       = rx_byte;
  assign code_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule

`default_nettype wire
